// File: rtl/para_pkg.sv
// Shared definitions for the parallel accumulator core array.
// Opcodes, the field encodings that split opcode 7 into HALT/SYNC,
// and helpers that derive the instruction and core-select widths.
package para_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 3'd0,
    OP_LDI = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_SYS = 3'd7
  } opcode_e;

  // field[0] of an OP_SYS instruction selects between halt and barrier
  localparam logic FIELD_HALT = 1'b0;
  localparam logic FIELD_SYNC = 1'b1;

  function automatic int instr_w(input int pc_w);
    return OPCODE_W + pc_w;
  endfunction

  function automatic int core_idx_w(input int num_cores);
    return (num_cores <= 1) ? 1 : $clog2(num_cores);
  endfunction

endpackage

// File: rtl/para_core.sv
// One 1-bit accumulator core: private program memory, PC, accumulator,
// halt flag and single-cycle decode/execute.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (also clears memory)
//   restart         synchronous clear of pc/acc/halted, memory kept
//   run             1 = execute, 0 = hold all state
//   prog_we/addr/data  program write (read-before-write against current PC)
//   sync_release    array-wide barrier release, sampled while at SYNC
//   acc, halted, pc architectural state
//   at_sync         core is parked on a SYNC instruction
//   pc_req          core advances its PC on its own (not halted, not at SYNC);
//                   any asserted pc_req in the array blocks the barrier
module para_core
  import para_pkg::*;
#(
  parameter int PC_W    = 3,
  parameter int INSTR_W = instr_w(PC_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               run,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               sync_release,
  output logic               acc,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic               at_sync,
  output logic               pc_req
);

  localparam int DEPTH = 2 ** PC_W;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] instr;
  opcode_e            opcode;
  logic [PC_W-1:0]    field;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_nxt;
  logic               acc_nxt;
  logic               halted_nxt;
  logic               exec;

  // Combinational fetch: the instruction at pc executes on the coming edge.
  assign instr  = mem[pc];
  assign opcode = opcode_e'(instr[INSTR_W-1:PC_W]);
  assign field  = instr[PC_W-1:0];
  assign pc_inc = pc + PC_W'(1);   // wraps modulo 2**PC_W
  assign exec   = run & ~halted;

  assign at_sync = ~halted & (opcode == OP_SYS) & (field[0] == FIELD_SYNC);
  assign pc_req  = ~halted & ~at_sync;

  always_comb begin
    acc_nxt    = acc;
    pc_nxt     = pc;
    halted_nxt = halted;
    if (exec) begin
      case (opcode)
        OP_NOP: pc_nxt = pc_inc;
        OP_LDI: begin acc_nxt = field[0];         pc_nxt = pc_inc; end
        OP_AND: begin acc_nxt = acc & field[0];   pc_nxt = pc_inc; end
        OP_OR:  begin acc_nxt = acc | field[0];   pc_nxt = pc_inc; end
        OP_XOR: begin acc_nxt = acc ^ field[0];   pc_nxt = pc_inc; end
        OP_JMP: pc_nxt = field;
        OP_JZ:  pc_nxt = (acc == 1'b0) ? field : pc_inc;
        OP_SYS: begin
          if (field[0] == FIELD_SYNC) begin
            // parked until the whole array agrees to step past the barrier
            if (sync_release) pc_nxt = pc_inc;
          end else begin
            halted_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      acc    <= 1'b0;
      halted <= 1'b0;
    end else if (restart) begin
      pc     <= '0;
      acc    <= 1'b0;
      halted <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      acc    <= acc_nxt;
      halted <= halted_nxt;
    end
  end

  // Writes land regardless of run/restart; the fetch above still sees the
  // old word on the write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: rtl/para_core_array.sv
// Array of NUM_CORES independent 1-bit accumulator cores with run/freeze,
// runtime program load, synchronous restart and a SYNC barrier.
// Ports:
//   clk, preset     clock, asynchronous active-high reset (clears memory too)
//   restart         synchronous restart of every core, memory kept
//   run             1 = cores execute, 0 = everything frozen
//   prog_we/core/addr/data  program write; out-of-range core index ignored
//   acc_out         accumulator per core (bit i = core i)
//   halted          halt flag per core
//   all_halted      AND of halted
//   pc_out          PCs packed, core i at [i*PC_W +: PC_W]
module para_core_array
  import para_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int PC_W       = 3,
  parameter int CORE_IDX_W = core_idx_w(NUM_CORES),
  parameter int INSTR_W    = instr_w(PC_W)
) (
  input  logic                      clk,
  input  logic                      preset,
  input  logic                      restart,
  input  logic                      run,
  input  logic                      prog_we,
  input  logic [CORE_IDX_W-1:0]     prog_core,
  input  logic [PC_W-1:0]           prog_addr,
  input  logic [INSTR_W-1:0]        prog_data,
  output logic [NUM_CORES-1:0]      acc_out,
  output logic [NUM_CORES-1:0]      halted,
  output logic                      all_halted,
  output logic [NUM_CORES*PC_W-1:0] pc_out
);

  logic [NUM_CORES-1:0] at_sync;
  logic [NUM_CORES-1:0] pc_req;
  logic                 sync_release;

  // Barrier opens once nobody is still stepping on its own (every core is
  // halted or parked) and somebody is actually parked.
  assign sync_release = run & (|at_sync) & ~(|pc_req);
  assign all_halted   = &halted;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    para_core #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
    ) u_core (
      .clk          (clk),
      .rst          (preset),
      .restart      (restart),
      .run          (run),
      .prog_we      (prog_we && (prog_core == CORE_IDX_W'(i))),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .sync_release (sync_release),
      .acc          (acc_out[i]),
      .halted       (halted[i]),
      .pc           (pc_out[i*PC_W +: PC_W]),
      .at_sync      (at_sync[i]),
      .pc_req       (pc_req[i])
    );
  end

endmodule

// File: tb/tb_para_core_array.sv
// Bench for para_core_array: a 4-core instance carries the main sequence,
// a 3-core instance sharing the same stimulus shows that a write to a
// non-existent core index is dropped.
module tb_para_core_array;

  localparam int W  = 1 + 4 + 4 + 12;  // {all_halted, halted, acc, pc3..pc0}
  localparam int W3 = 1 + 3 + 3 + 9;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       preset, restart, run, prog_we;
  logic [1:0] prog_core;
  logic [2:0] prog_addr;
  logic [5:0] prog_data;

  logic [3:0]  acc_out, halted;
  logic        all_halted;
  logic [11:0] pc_out;
  logic [2:0]  acc_out3, halted3;
  logic        all_halted3;
  logic [8:0]  pc_out3;

  always #5 clk = ~clk;

  para_core_array #(.NUM_CORES(4), .PC_W(3)) dut (
    .clk(clk), .preset(preset), .restart(restart), .run(run),
    .prog_we(prog_we), .prog_core(prog_core), .prog_addr(prog_addr),
    .prog_data(prog_data), .acc_out(acc_out), .halted(halted),
    .all_halted(all_halted), .pc_out(pc_out)
  );

  para_core_array #(.NUM_CORES(3), .PC_W(3)) dut3 (
    .clk(clk), .preset(preset), .restart(restart), .run(run),
    .prog_we(prog_we), .prog_core(prog_core), .prog_addr(prog_addr),
    .prog_data(prog_data), .acc_out(acc_out3), .halted(halted3),
    .all_halted(all_halted3), .pc_out(pc_out3)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [W3-1:0] exp3_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic ah, input logic [3:0] h, input logic [3:0] a,
                                      input logic [2:0] p0, input logic [2:0] p1,
                                      input logic [2:0] p2, input logic [2:0] p3);
    return {ah, h, a, p3, p2, p1, p0};
  endfunction

  function automatic logic [W3-1:0] mk3(input logic ah, input logic [2:0] h, input logic [2:0] a,
                                        input logic [2:0] p0, input logic [2:0] p1,
                                        input logic [2:0] p2);
    return {ah, h, a, p2, p1, p0};
  endfunction

  function automatic logic [W-1:0] obs();
    return {all_halted, halted, acc_out, pc_out};
  endfunction

  function automatic logic [W3-1:0] obs3();
    return {all_halted3, halted3, acc_out3, pc_out3};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock edge; the expected state after it is queued first, then
  // popped and compared once the edge has happened.
  task automatic step(input string tag, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check(tag, obs(), exp_q.pop_front());
  endtask

  task automatic step_both(input string tag, input logic [W-1:0] exp, input logic [W3-1:0] exp3);
    exp_q.push_back(exp);
    exp3_q.push_back(exp3);
    @(posedge clk); #1;
    check(tag, obs(), exp_q.pop_front());
    check({tag, "_3core"}, obs3(), exp3_q.pop_front());
  endtask

  task automatic load(input logic [1:0] core, input logic [2:0] addr, input logic [5:0] data);
    prog_core = core; prog_addr = addr; prog_data = data; prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic wr_step(input logic [1:0] core, input logic [2:0] addr, input logic [5:0] data,
                         input string tag, input logic [W-1:0] exp);
    prog_core = core; prog_addr = addr; prog_data = data; prog_we = 1'b1;
    step(tag, exp);
    prog_we = 1'b0;
  endtask

  // preset pulse between edges; state must clear before the next edge
  task automatic async_clear(input string tag);
    #3 preset = 1'b1;
    #1;
    check(tag, obs(), '0);
    check({tag, "_3core"}, obs3(), '0);
    #1 preset = 1'b0;
  endtask

  localparam logic [5:0] I_NOP  = 6'h00, I_LDI0 = 6'h08, I_LDI1 = 6'h09, I_OR1 = 6'h19,
                         I_XOR1 = 6'h21, I_JMP5 = 6'h2D, I_JZ0 = 6'h30, I_HALT = 6'h38,
                         I_SYNC = 6'h39;

  // ---------------- stimulus ----------------
  initial begin
    preset = 1'b1; restart = 1'b0; run = 1'b0; prog_we = 1'b0;
    prog_core = '0; prog_addr = '0; prog_data = '0;
    #2;
    check("reset", obs(), '0);
    check("reset_3core", obs3(), '0);
    @(posedge clk); #1 preset = 1'b0;

    // basic exec on core0, JZ loop on core2, wrapping NOPs on core1, core3 halts
    load(0, 0, I_LDI1); load(0, 1, I_XOR1); load(0, 2, I_OR1); load(0, 3, I_HALT);
    load(2, 0, I_LDI0); load(2, 1, I_JZ0);  load(3, 0, I_HALT);
    check("load_frozen", obs(), '0);
    run = 1'b1;
    for (int e = 1; e <= 9; e++)
      step("exec", mk(1'b0, (e >= 4) ? 4'b1001 : 4'b1000, (e == 2) ? 4'b0000 : 4'b0001,
                      3'((e < 3) ? e : 3), 3'(e % 8), 3'(e % 2), 3'd0));

    // asynchronous preset wipes state and memory
    async_clear("preset_async");
    for (int e = 1; e <= 3; e++)
      step("mem_clear", mk(1'b0, 4'b0000, 4'b0000, 3'(e), 3'(e), 3'(e), 3'(e)));

    // barrier: core0 waits at addr0 until core1 reaches its SYNC at addr3
    run = 1'b0;
    load(0, 0, I_SYNC); load(0, 1, I_LDI1); load(1, 3, I_SYNC);
    load(2, 0, I_HALT); load(3, 0, I_HALT);
    restart = 1'b1;
    step("restart_frozen", '0);
    restart = 1'b0;
    run = 1'b1;
    for (int e = 1; e <= 3; e++)
      step("barrier_wait", mk(1'b0, 4'b1100, 4'b0000, 3'd0, 3'(e), 3'd0, 3'd0));
    step("barrier_release", mk(1'b0, 4'b1100, 4'b0000, 3'd1, 3'd4, 3'd0, 3'd0));
    step("after_barrier", mk(1'b0, 4'b1100, 4'b0001, 3'd2, 3'd5, 3'd0, 3'd0));

    // freeze, including a write accepted while frozen
    run = 1'b0;
    wr_step(1, 6, I_JMP5, "freeze_wr", mk(1'b0, 4'b1100, 4'b0001, 3'd2, 3'd5, 3'd0, 3'd0));
    for (int e = 0; e < 3; e++)
      step("freeze", mk(1'b0, 4'b1100, 4'b0001, 3'd2, 3'd5, 3'd0, 3'd0));

    // overwrite the instruction under core1's PC while running
    run = 1'b1;
    wr_step(1, 5, I_LDI1, "rbw_old", mk(1'b0, 4'b1100, 4'b0001, 3'd3, 3'd6, 3'd0, 3'd0));
    step("rbw_jmp", mk(1'b0, 4'b1100, 4'b0001, 3'd4, 3'd5, 3'd0, 3'd0));
    step("rbw_new", mk(1'b0, 4'b1100, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));

    // halt everything, then restart and re-run the same programs
    run = 1'b0;
    wr_step(0, 5, I_HALT, "halt_load0", mk(1'b0, 4'b1100, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));
    wr_step(1, 6, I_HALT, "halt_load1", mk(1'b0, 4'b1100, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));
    run = 1'b1;
    step("all_halted", mk(1'b1, 4'b1111, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));
    step("halt_hold",  mk(1'b1, 4'b1111, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));
    restart = 1'b1;
    step("restart", '0);
    restart = 1'b0;
    for (int e = 1; e <= 3; e++)
      step("rerun_wait", mk(1'b0, 4'b1100, 4'b0000, 3'd0, 3'(e), 3'd0, 3'd0));
    step("rerun_release", mk(1'b0, 4'b1100, 4'b0000, 3'd1, 3'd4, 3'd0, 3'd0));
    step("rerun_ldi0",    mk(1'b0, 4'b1100, 4'b0001, 3'd2, 3'd5, 3'd0, 3'd0));
    step("rerun_ldi1",    mk(1'b0, 4'b1100, 4'b0011, 3'd3, 3'd6, 3'd0, 3'd0));
    step("rerun_halt1",   mk(1'b0, 4'b1110, 4'b0011, 3'd4, 3'd6, 3'd0, 3'd0));
    step("rerun_nop",     mk(1'b0, 4'b1110, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));
    step("rerun_halt0",   mk(1'b1, 4'b1111, 4'b0011, 3'd5, 3'd6, 3'd0, 3'd0));

    // preset while restart is held still clears memory
    restart = 1'b1;
    async_clear("preset_in_restart");
    step("restart_hold", '0);
    restart = 1'b0;
    step("mem_clear2", mk(1'b0, 4'b0000, 4'b0000, 3'd1, 3'd1, 3'd1, 3'd1));

    // core index 3 exists on the 4-core array but not on the 3-core one
    run = 1'b0;
    wr_step(3, 0, I_HALT, "wr_core3", mk(1'b0, 4'b0000, 4'b0000, 3'd1, 3'd1, 3'd1, 3'd1));
    restart = 1'b1;
    step_both("restart5", '0, '0);
    restart = 1'b0;
    run = 1'b1;
    step_both("ignored_write", mk(1'b0, 4'b1000, 4'b0000, 3'd1, 3'd1, 3'd1, 3'd0),
              mk3(1'b0, 3'b000, 3'b000, 3'd1, 3'd1, 3'd1));
    step_both("ignored_write2", mk(1'b0, 4'b1000, 4'b0000, 3'd2, 3'd2, 3'd2, 3'd0),
              mk3(1'b0, 3'b000, 3'b000, 3'd2, 3'd2, 3'd2));

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
